// File: rtl/hamming74_stream_encoder.sv
// Streaming Hamming(7,4) encoder: bytes in, two registered 7-bit codewords out (low nibble first),
// with a one-shot single-bit error injector and a wrapping handshake counter.
module hamming74_stream_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_code,
    output logic        out_last,
    input  logic        inj_req,
    input  logic [2:0]  inj_pos,
    output logic        inj_armed,
    output logic [15:0] cw_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned POS_W  = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [POS_W-1:0] POS_NONE = POS_W'(7);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   byte_q;
    logic [POS_W-1:0]    inj_pos_q;

    logic                load;
    logic                in_hs;
    logic                out_hs;
    logic [NIB_W-1:0]    nibble;
    logic [CODE_W-1:0]   flip_mask;
    logic [CODE_W-1:0]   load_code;

    // Codeword layout: {p6, p5, d3, p3, d2, d1, d0}
    function automatic logic [CODE_W-1:0] encode(input logic [NIB_W-1:0] d);
        return {d[3] ^ d[2] ^ d[0],
                d[3] ^ d[1] ^ d[0],
                d[3],
                d[2] ^ d[1] ^ d[0],
                d[2],
                d[1],
                d[0]};
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (in_hs) state_nxt = ST_LO;
            ST_LO:    if (load)  state_nxt = ST_HI;
            ST_HI:    if (load)  state_nxt = in_hs ? ST_LO : ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake decode and codeword to load; the output register is free when empty or draining
    always_comb begin
        load      = (state != ST_EMPTY) && (!out_valid || out_ready);
        in_ready  = !reset && ((state == ST_EMPTY) || ((state == ST_HI) && load));
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        nibble    = (state == ST_HI) ? byte_q[DATA_W-1:NIB_W] : byte_q[NIB_W-1:0];
        flip_mask = '0;
        if (inj_armed && (inj_pos_q != POS_NONE)) begin
            flip_mask = CODE_W'(1) << inj_pos_q;
        end
        load_code = encode(nibble) ^ flip_mask;
    end

    // Byte holding, output register, injector and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q    <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            inj_armed <= 1'b0;
            inj_pos_q <= '0;
            cw_count  <= '0;
        end else begin
            if (in_hs) begin
                byte_q <= in_data;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_code  <= load_code;
                out_last  <= (state == ST_HI);
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            // A request on a load edge re-arms for the next load rather than the current one
            if (inj_req) begin
                inj_armed <= 1'b1;
                inj_pos_q <= inj_pos;
            end else if (load) begin
                inj_armed <= 1'b0;
            end

            if (out_hs) begin
                cw_count <= cw_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming74_stream_encoder.sv
// Self-checking bench for hamming74_stream_encoder: directed scenarios plus a randomized
// stream scored against a queue-based reference model.
module tb_hamming74_stream_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_code;
    logic        out_last;
    logic        inj_req;
    logic [2:0]  inj_pos;
    logic        inj_armed;
    logic [15:0] cw_count;

    int tests_run    = 0;
    int tests_failed = 0;

    hamming74_stream_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .inj_req   (inj_req),
        .inj_pos   (inj_pos),
        .inj_armed (inj_armed),
        .cw_count  (cw_count)
    );

    always #5 clk = ~clk;

    // Reference encoder: place data bits, then choose each parity so its check group XORs to zero
    function automatic logic [6:0] model_enc(input logic [3:0] d);
        logic [6:0] c;
        c    = '0;
        c[0] = d[0];
        c[1] = d[1];
        c[2] = d[2];
        c[4] = d[3];
        c[6] = ^(c & 7'h55);
        c[5] = ^(c & 7'h33);
        c[3] = ^(c & 7'h0F);
        return c;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {^(c & 7'h55), ^(c & 7'h33), ^(c & 7'h0F)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        inj_req   = 1'b0;
        inj_pos   = 3'd0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        inj_req   = 1'b0;
        inj_pos   = 3'd0;
        reset     = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_code !== 7'h00 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b code=%h last=%b, want 0/00/0", out_valid, out_code, out_last);
        end
        tests_run++;
        if (inj_armed !== 1'b0 || cw_count !== 16'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: armed=%b cw=%0d in_ready=%b, want 0/0/0", inj_armed, cw_count, in_ready);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB5;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL directed_latency: out_valid=%b one edge after accept, want 0", out_valid);
        end
        tick();
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 7'h25 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL directed_lo: valid=%b code=%h last=%b, want 1/25/0", out_valid, out_code, out_last);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL directed_hi_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 7'h33 || out_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL directed_hi: valid=%b code=%h last=%b, want 1/33/1", out_valid, out_code, out_last);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || cw_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL directed_done: valid=%b cw=%0d, want 0/2", out_valid, cw_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] exp_cw [6];
        int idx;
        int got;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            exp_cw[2*i]   = {1'b0, model_enc(bytes[i][3:0])};
            exp_cw[2*i+1] = {1'b1, model_enc(bytes[i][7:4])};
        end
        do_reset();
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? bytes[idx] : 8'h00;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                tests_run++;
                if (got >= 6 || {out_last, out_code} !== exp_cw[got]) begin
                    tests_failed++;
                    $display("FAIL b2b_code[%0d]: last/code=%h, want %h", got, {out_last, out_code},
                             (got < 6) ? exp_cw[got] : 8'hXX);
                end
                if (!out_last) begin
                    tests_run++;
                    if (in_ready !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL b2b_hi_ready[%0d]: in_ready=%b, want 1", got, in_ready);
                    end
                end
                got++;
            end else if (got > 0 && got < 6) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_bubble: out_valid=0 after %0d codewords, want 1", got);
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        tests_run++;
        if (got !== 6 || cw_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL b2b_count: got=%0d cw=%0d, want 6/6", got, cw_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hB5;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_code !== 7'h25 || out_last !== 1'b0 ||
                in_ready !== 1'b0 || cw_count !== 16'd0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b code=%h last=%b rdy=%b cw=%0d, want 1/25/0/0/0",
                         i, out_valid, out_code, out_last, in_ready, cw_count);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 7'h33 || out_last !== 1'b1 || cw_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL bp_release: valid=%b code=%h last=%b cw=%0d, want 1/33/1/1",
                     out_valid, out_code, out_last, cw_count);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || cw_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL bp_drain: valid=%b cw=%0d, want 0/2", out_valid, cw_count);
        end
    endtask

    task automatic test_injection();
        logic [2:0] pos_list [2];
        logic [6:0] exp_lo;
        pos_list[0] = 3'd2;
        pos_list[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            out_ready = 1'b1;
            inj_req   = 1'b1;
            inj_pos   = pos_list[k];
            tick();
            inj_req = 1'b0;
            inj_pos = 3'd0;
            in_valid = 1'b1;
            in_data  = 8'hB5;
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (inj_armed !== 1'b1) begin
                tests_failed++;
                $display("FAIL inj_armed_pre[pos%0d]: armed=%b, want 1", pos_list[k], inj_armed);
            end
            tick();
            exp_lo = (pos_list[k] == 3'd7) ? model_enc(4'h5) : (model_enc(4'h5) ^ (7'h01 << pos_list[k]));
            tests_run++;
            if (out_code !== exp_lo || out_last !== 1'b0 || inj_armed !== 1'b0) begin
                tests_failed++;
                $display("FAIL inj_lo[pos%0d]: code=%h last=%b armed=%b, want %h/0/0",
                         pos_list[k], out_code, out_last, inj_armed, exp_lo);
            end
            tick();
            tests_run++;
            if (out_code !== model_enc(4'hB) || out_last !== 1'b1) begin
                tests_failed++;
                $display("FAIL inj_hi[pos%0d]: code=%h last=%b, want %h/1",
                         pos_list[k], out_code, out_last, model_enc(4'hB));
            end
        end
        // Request landing on a load edge must skip that load and hit the next one
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hB5;
        tick();
        in_valid = 1'b0;
        inj_req  = 1'b1;
        inj_pos  = 3'd0;
        tick();
        inj_req = 1'b0;
        tests_run++;
        if (out_code !== model_enc(4'h5) || inj_armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL inj_coincide_lo: code=%h armed=%b, want %h/1", out_code, inj_armed, model_enc(4'h5));
        end
        tick();
        tests_run++;
        if (out_code !== (model_enc(4'hB) ^ 7'h01) || inj_armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL inj_coincide_hi: code=%h armed=%b, want %h/0",
                     out_code, inj_armed, model_enc(4'hB) ^ 7'h01);
        end
    endtask

    task automatic test_exhaustive();
        int seen;
        do_reset();
        out_ready = 1'b1;
        seen = 0;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_data  = {4'(2*b + 1), 4'(2*b)};
            tick();
            in_valid = 1'b0;
            tick();
            for (int h = 0; h < 2; h++) begin
                tests_run++;
                if (out_valid !== 1'b1 || syndrome(out_code) !== 3'b000 ||
                    {out_code[4], out_code[2], out_code[1], out_code[0]} !== 4'(2*b + h)) begin
                    tests_failed++;
                    $display("FAIL exh_nibble[%0d]: valid=%b code=%h syn=%b, want data %h syn 000",
                             2*b + h, out_valid, out_code, syndrome(out_code), 4'(2*b + h));
                end
                seen++;
                tick();
            end
        end
        tests_run++;
        if (cw_count !== 16'(seen)) begin
            tests_failed++;
            $display("FAIL exh_count: cw=%0d, want %0d", cw_count, seen);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick();
        inj_req = 1'b1;
        inj_pos = 3'd1;
        tick();
        inj_req = 1'b0;
        reset   = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_code !== 7'h00 || cw_count !== 16'd0 ||
            inj_armed !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: valid=%b code=%h cw=%0d armed=%b rdy=%b, want 0/00/0/0/0",
                     out_valid, out_code, cw_count, inj_armed, in_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_release: rdy=%b valid=%b, want 1/0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_code !== model_enc(4'hA) || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_lo: code=%h last=%b, want %h/0", out_code, out_last, model_enc(4'hA));
        end
        tick();
        tests_run++;
        if (out_code !== model_enc(4'h5) || out_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_hi: code=%h last=%b, want %h/1", out_code, out_last, model_enc(4'h5));
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q [$];
        logic [7:0] front;
        logic [15:0] exp_cw;
        logic        held;
        logic [7:0]  held_val;
        int          drain;
        do_reset();
        exp_cw = '0;
        held   = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) begin
                tests_run++;
                if (out_valid !== 1'b1 || {out_last, out_code} !== held_val) begin
                    tests_failed++;
                    $display("FAIL rnd_stable[%0d]: valid=%b last/code=%h, want 1/%h",
                             cyc, out_valid, {out_last, out_code}, held_val);
                end
            end
            if (out_valid && out_ready) begin
                front = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                tests_run++;
                if ({out_last, out_code} !== front) begin
                    tests_failed++;
                    $display("FAIL rnd_code[%0d]: last/code=%h, want %h", cyc, {out_last, out_code}, front);
                end
                exp_cw = exp_cw + 16'd1;
            end
            held     = out_valid && !out_ready;
            held_val = {out_last, out_code};
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, model_enc(in_data[3:0])});
                exp_q.push_back({1'b1, model_enc(in_data[7:4])});
            end
            tick();
            if ((cyc % 50) == 49) begin
                tests_run++;
                if (cw_count !== exp_cw) begin
                    tests_failed++;
                    $display("FAIL rnd_cw[%0d]: cw=%0d, want %0d", cyc, cw_count, exp_cw);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (drain < 10) begin
            #1;
            if (out_valid) begin
                front = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                tests_run++;
                if ({out_last, out_code} !== front) begin
                    tests_failed++;
                    $display("FAIL rnd_drain: last/code=%h, want %h", {out_last, out_code}, front);
                end
                exp_cw = exp_cw + 16'd1;
            end
            tick();
            drain++;
        end
        tests_run++;
        if (exp_q.size() != 0 || cw_count !== exp_cw) begin
            tests_failed++;
            $display("FAIL rnd_final: pending=%0d cw=%0d, want 0/%0d", exp_q.size(), cw_count, exp_cw);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        inj_req   = 1'b0;
        inj_pos   = 3'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_injection();
        test_exhaustive();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
